// File: rtl/instr_fetch.sv
// Instruction fetch unit: 256x17 program memory, pc sequencing, jump/halt redirect
// and one-cycle hold for two-cycle operations. All outputs are registered.
module instr_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        prog_we,
    input  logic [7:0]  prog_addr,
    input  logic [16:0] prog_data,
    input  logic [4:0]  fl,
    output logic [16:0] instruction,
    output logic [7:0]  pc,
    output logic        valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [4:0] OP_MUL0 = 5'b10000;
    localparam logic [4:0] OP_MUL1 = 5'b10001;
    localparam logic [4:0] OP_JMP  = 5'b10011;
    localparam logic [4:0] OP_JZ   = 5'b10100;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    state_t      state, state_n;
    logic [16:0] mem [256];
    logic [16:0] fetch_word;
    logic [16:0] instr_n;
    logic [7:0]  pc_n;
    logic        valid_n, halted_n;
    logic [4:0]  op;
    logic        unused_fl;

    assign unused_fl  = ^fl[4:1];
    assign op         = instruction[16:12];
    assign fetch_word = mem[pc];

    // Writes are independent of state and reset; a same-edge fetch sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            valid       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instruction <= instr_n;
            valid       <= valid_n;
            halted      <= halted_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        instr_n  = instruction;
        valid_n  = valid;
        halted_n = halted;
        case (state)
            IDLE, HALT: begin
                if (run) begin
                    state_n  = FETCH;
                    pc_n     = '0;
                    instr_n  = '0;
                    valid_n  = 1'b0;
                    halted_n = 1'b0;
                end
            end
            FETCH: begin
                if (valid && (op == OP_JMP || (op == OP_JZ && fl[0]))) begin
                    pc_n    = instruction[7:0];
                    instr_n = '0;
                    valid_n = 1'b0;
                end else if (valid && op == OP_HLT) begin
                    state_n  = HALT;
                    instr_n  = '0;
                    valid_n  = 1'b0;
                    halted_n = 1'b1;
                end else if (valid && (op == OP_MUL0 || op == OP_MUL1)) begin
                    state_n = HOLD;
                end else begin
                    instr_n = fetch_word;
                    valid_n = 1'b1;
                    pc_n    = pc + 8'd1;
                end
            end
            HOLD: begin
                // Leaving HOLD fetches directly so the held word is not decoded twice.
                state_n = FETCH;
                instr_n = fetch_word;
                valid_n = 1'b1;
                pc_n    = pc + 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: sequencing, redirects, hold,
// halt, reset behaviour and pc wrap with read-before-write.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        run;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [16:0] prog_data;
    logic [4:0]  fl;
    logic [16:0] instruction;
    logic [7:0]  pc;
    logic        valid;
    logic        halted;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .fl          (fl),
        .instruction (instruction),
        .pc          (pc),
        .valid       (valid),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [16:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic restart();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [16:0] e_instr,
                              input logic e_valid, input logic [7:0] e_pc,
                              input logic e_halted);
        n_checks++;
        assert (instruction === e_instr) else begin
            n_fail++;
            $error("FAIL %s instruction: got %h expected %h", tag, instruction, e_instr);
        end
        n_checks++;
        assert (valid === e_valid) else begin
            n_fail++;
            $error("FAIL %s valid: got %b expected %b", tag, valid, e_valid);
        end
        n_checks++;
        assert (pc === e_pc) else begin
            n_fail++;
            $error("FAIL %s pc: got %h expected %h", tag, pc, e_pc);
        end
        n_checks++;
        assert (halted === e_halted) else begin
            n_fail++;
            $error("FAIL %s halted: got %b expected %b", tag, halted, e_halted);
        end
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        fl        = '0;
        step();
        expect_out("reset", 17'h00000, 1'b0, 8'h00, 1'b0);

        // Program loaded while reset is held
        wr(8'h00, 17'h01234);
        wr(8'h01, 17'h05678);
        wr(8'h02, 17'h1F000);
        wr(8'h03, 17'h0DEAD);
        rst = 1'b0;
        step();
        step();
        expect_out("idle_wait", 17'h00000, 1'b0, 8'h00, 1'b0);

        run = 1'b1;
        step();
        run = 1'b0;
        expect_out("start", 17'h00000, 1'b0, 8'h00, 1'b0);
        step(); expect_out("seq_w0", 17'h01234, 1'b1, 8'h01, 1'b0);
        step(); expect_out("seq_w1", 17'h05678, 1'b1, 8'h02, 1'b0);
        step(); expect_out("seq_hlt", 17'h1F000, 1'b1, 8'h03, 1'b0);
        step(); expect_out("halt", 17'h00000, 1'b0, 8'h03, 1'b1);
        step(); expect_out("halt_stay", 17'h00000, 1'b0, 8'h03, 1'b1);

        // JMP, loaded while halted, restarted via run from HALT
        wr(8'h00, 17'h13040);
        wr(8'h40, 17'h0ABCD);
        expect_out("halt_write", 17'h00000, 1'b0, 8'h03, 1'b1);
        run = 1'b1;
        step();
        run = 1'b0;
        expect_out("jmp_start", 17'h00000, 1'b0, 8'h00, 1'b0);
        step(); expect_out("jmp_word", 17'h13040, 1'b1, 8'h01, 1'b0);
        step(); expect_out("jmp_bubble", 17'h00000, 1'b0, 8'h40, 1'b0);
        step(); expect_out("jmp_target", 17'h0ABCD, 1'b1, 8'h41, 1'b0);

        // JZ taken and not taken
        wr(8'h00, 17'h14010);
        wr(8'h01, 17'h0C0DE);
        wr(8'h10, 17'h0BEEF);
        fl = 5'b00001;
        restart();
        step(); expect_out("jz_t_word", 17'h14010, 1'b1, 8'h01, 1'b0);
        step(); expect_out("jz_t_bubble", 17'h00000, 1'b0, 8'h10, 1'b0);
        step(); expect_out("jz_t_target", 17'h0BEEF, 1'b1, 8'h11, 1'b0);
        fl = 5'b11110;
        restart();
        step(); expect_out("jz_n_word", 17'h14010, 1'b1, 8'h01, 1'b0);
        step(); expect_out("jz_n_next", 17'h0C0DE, 1'b1, 8'h02, 1'b0);
        fl = 5'b00000;

        // Two-cycle operation holds one extra cycle
        wr(8'h00, 17'h10305);
        wr(8'h01, 17'h01111);
        restart();
        step(); expect_out("hold_w0", 17'h10305, 1'b1, 8'h01, 1'b0);
        step(); expect_out("hold_w1", 17'h10305, 1'b1, 8'h01, 1'b0);
        step(); expect_out("hold_next", 17'h01111, 1'b1, 8'h02, 1'b0);

        // Reset while in HOLD, then memory still intact
        restart();
        step(); expect_out("hrst_w0", 17'h10305, 1'b1, 8'h01, 1'b0);
        step(); expect_out("hrst_hold", 17'h10305, 1'b1, 8'h01, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_out("hrst_reset", 17'h00000, 1'b0, 8'h00, 1'b0);
        step(); expect_out("hrst_idle", 17'h00000, 1'b0, 8'h00, 1'b0);
        run = 1'b1;
        step();
        run = 1'b0;
        step(); expect_out("hrst_mem", 17'h10305, 1'b1, 8'h01, 1'b0);

        // JMP to its own address loops
        wr(8'h00, 17'h13000);
        restart();
        step(); expect_out("self_w0", 17'h13000, 1'b1, 8'h01, 1'b0);
        step(); expect_out("self_b0", 17'h00000, 1'b0, 8'h00, 1'b0);
        step(); expect_out("self_w1", 17'h13000, 1'b1, 8'h01, 1'b0);
        step(); expect_out("self_b1", 17'h00000, 1'b0, 8'h00, 1'b0);

        // Jump to 255, wrap to 0, read-before-write on mem[0]
        wr(8'h00, 17'h130FF);
        wr(8'hFF, 17'h0AAAA);
        restart();
        step(); expect_out("wrap_jmp", 17'h130FF, 1'b1, 8'h01, 1'b0);
        step(); expect_out("wrap_bubble", 17'h00000, 1'b0, 8'hFF, 1'b0);
        step(); expect_out("wrap_ff", 17'h0AAAA, 1'b1, 8'h00, 1'b0);
        prog_we   = 1'b1;
        prog_addr = 8'h00;
        prog_data = 17'h02222;
        step();
        prog_we   = 1'b0;
        expect_out("wrap_rbw", 17'h130FF, 1'b1, 8'h01, 1'b0);
        step(); expect_out("wrap_bubble2", 17'h00000, 1'b0, 8'hFF, 1'b0);
        step(); expect_out("wrap_ff2", 17'h0AAAA, 1'b1, 8'h00, 1'b0);
        step(); expect_out("wrap_new", 17'h02222, 1'b1, 8'h01, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
